simple_spi_master: RTL

SPI master (initiator) that exchanges one word of fixed WIDTH with a single slave per transaction. Mode CPOL=0, CPHA=0, MSB first, active-low chip select. It sits between system logic and the SPI pins and generates pin_ncs, pin_clk and pin_mosi from system_clk through an integer divider. The transmit word is loaded on a start request, and the received word is presented with a one-cycle done strobe.

---
 rtl/simple_spi_master.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/simple_spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one WIDTH-bit word per transaction.
// SCK half-period is CLKDIV system_clk cycles; MISO is sampled at the end of each high phase.
module simple_spi_master #(
   parameter int WIDTH  = 32,
   parameter int CLKDIV = 4
) (
   input  logic             system_clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value_mosi,
   output logic [WIDTH-1:0] value_miso,
   output logic             busy,
   output logic             done,
   output logic             pin_ncs,
   output logic             pin_clk,
   output logic             pin_mosi,
   input  logic             pin_miso
);

   localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic [DW-1:0]    div_q, div_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             ncs_q, ncs_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             div_last;

   assign div_last = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      rx_d    = rx_q;
      div_d   = '0;
      bit_d   = bit_q;
      ncs_d   = ncs_q;
      sclk_d  = sclk_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (state_q != S_IDLE && !div_last) begin
         div_d = div_q + DW'(1);
      end
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               sr_d    = value_mosi;
               ncs_d   = 1'b0;
               busy_d  = 1'b1;
               bit_d   = '0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (div_last) begin
               sclk_d  = 1'b1;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            // Sampling at the end of high gives the slave nearly a full period to respond
            if (div_last) begin
               sr_d    = {sr_q[WIDTH-2:0], pin_miso};
               bit_d   = bit_q + BW'(1);
               sclk_d  = 1'b0;
               state_d = S_LOW;
            end
         end
         S_LOW: begin
            if (div_last) begin
               if (bit_q < BIT_LAST) begin
                  sclk_d  = 1'b1;
                  state_d = S_HIGH;
               end else begin
                  ncs_d   = 1'b1;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (div_last) begin
               rx_d    = sr_q;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // MOSI is registered so it moves on the same edge as SCK falling / CS falling
      mosi_d = ncs_d ? 1'b0 : sr_d[WIDTH-1];
   end

   always_ff @(posedge system_clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         rx_q    <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         ncs_q   <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         rx_q    <= rx_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         ncs_q   <= ncs_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign value_miso = rx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pin_ncs    = ncs_q;
   assign pin_clk    = sclk_q;
   assign pin_mosi   = mosi_q;

endmodule
